// File: rtl/wb8_xmem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : wb8_xmem_bridge
// Purpose  : Bridges an 8-bit Wishbone classic initiator onto the 32-bit
//            word-wide external-memory bus. Each byte access becomes one
//            32-bit word cycle with byte-lane selects. A one-word read buffer
//            answers repeated byte reads from the same word without a
//            downstream cycle.
//            Bit numbering is big-endian: byte offset 0 = bits [0:7] = sel[0].
// Ports    : clk, reset_n          clock, asynchronous active-low reset
//            s_*                   8-bit Wishbone responder side
//            m_*                   32-bit external-memory initiator side
//            flush_i               invalidates the read buffer
// Revision : 1.0  initial release
// ============================================================================
module wb8_xmem_bridge #(
    parameter int READ_BUFFER = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [0:23] s_adr_i,
    input  logic [0:7]  s_dat_i,
    output logic [0:7]  s_dat_o,
    input  logic        s_we_i,
    input  logic [0:0]  s_sel_i,
    input  logic        s_stb_i,
    input  logic        s_cyc_i,
    output logic        s_ack_o,
    output logic [2:23] m_adr_o,
    output logic [0:31] m_dat_o,
    input  logic [0:31] m_dat_i,
    output logic        m_we_o,
    output logic [0:3]  m_sel_o,
    output logic        m_stb_o,
    output logic        m_cyc_o,
    input  logic        m_ack_i,
    input  logic        flush_i
);

    localparam logic c_buf_en = (READ_BUFFER != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t      r_state, w_state_next;
    logic [1:0]  r_lane, w_lane_next;
    logic        r_abort, w_abort_next;
    logic [0:31] r_buf_word, w_buf_word_next;
    logic [2:23] r_buf_tag, w_buf_tag_next;
    logic        r_buf_valid, w_buf_valid_next;

    logic        w_ack_next;
    logic [0:7]  w_dat_next;
    logic [2:23] w_m_adr_next;
    logic [0:31] w_m_dat_next;
    logic        w_m_we_next;
    logic [0:3]  w_m_sel_next;
    logic        w_m_stb_next;
    logic        w_m_cyc_next;

    logic [1:0]  w_lane;
    logic        w_req;
    logic        w_hit;

    assign w_lane = s_adr_i[22:23];
    assign w_req  = s_cyc_i && s_stb_i;
    // A flush in the same cycle as the lookup makes the buffer count as empty.
    assign w_hit  = c_buf_en && r_buf_valid && !flush_i && !s_we_i
                    && (r_buf_tag == s_adr_i[0:21]);

    always_comb begin
        w_state_next     = r_state;
        w_lane_next      = r_lane;
        w_abort_next     = r_abort;
        w_buf_word_next  = r_buf_word;
        w_buf_tag_next   = r_buf_tag;
        w_buf_valid_next = r_buf_valid;
        w_ack_next       = 1'b0;
        w_dat_next       = s_dat_o;
        w_m_adr_next     = m_adr_o;
        w_m_dat_next     = m_dat_o;
        w_m_we_next      = m_we_o;
        w_m_sel_next     = m_sel_o;
        w_m_stb_next     = m_stb_o;
        w_m_cyc_next     = m_cyc_o;

        case (r_state)
            ST_IDLE: begin
                w_abort_next = 1'b0;
                if (w_req) begin
                    w_lane_next = w_lane;
                    if (w_hit) begin
                        w_dat_next   = r_buf_word[{w_lane, 3'b000} +: 8];
                        w_ack_next   = 1'b1;
                        w_state_next = ST_ACK;
                    end else if (s_we_i && !s_sel_i[0]) begin
                        // Null write: acknowledge without touching the bus.
                        w_ack_next   = 1'b1;
                        w_state_next = ST_ACK;
                    end else begin
                        w_m_cyc_next = 1'b1;
                        w_m_stb_next = 1'b1;
                        w_m_adr_next = s_adr_i[0:21];
                        w_m_we_next  = s_we_i;
                        if (s_we_i) begin
                            // Lane 0 is the leftmost select bit.
                            w_m_sel_next = 4'b1000 >> w_lane;
                            w_m_dat_next = {4{s_dat_i}};
                        end else begin
                            w_m_sel_next = 4'b1111;
                        end
                        w_state_next = ST_BUS;
                    end
                end
            end

            ST_BUS: begin
                // Remember an initiator abort; the downstream cycle still completes.
                if (!s_cyc_i) begin
                    w_abort_next = 1'b1;
                end
                if (m_ack_i) begin
                    w_m_cyc_next = 1'b0;
                    w_m_stb_next = 1'b0;
                    if (!m_we_o) begin
                        w_dat_next = m_dat_i[{r_lane, 3'b000} +: 8];
                        if (c_buf_en) begin
                            w_buf_word_next  = m_dat_i;
                            w_buf_tag_next   = m_adr_o;
                            w_buf_valid_next = 1'b1;
                        end
                    end else if (r_buf_valid && (r_buf_tag == m_adr_o)) begin
                        // Keep the buffered word coherent with the written lane.
                        w_buf_word_next[{r_lane, 3'b000} +: 8] = m_dat_o[0:7];
                    end
                    if (r_abort || !s_cyc_i) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_ack_next   = 1'b1;
                        w_state_next = ST_ACK;
                    end
                end
            end

            ST_ACK: begin
                w_state_next = ST_IDLE;
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // Flush has priority over a coincident fill.
        if (flush_i) begin
            w_buf_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_lane      <= 2'd0;
            r_abort     <= 1'b0;
            r_buf_word  <= '0;
            r_buf_tag   <= '0;
            r_buf_valid <= 1'b0;
            s_ack_o     <= 1'b0;
            s_dat_o     <= '0;
            m_adr_o     <= '0;
            m_dat_o     <= '0;
            m_we_o      <= 1'b0;
            m_sel_o     <= '0;
            m_stb_o     <= 1'b0;
            m_cyc_o     <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_lane      <= w_lane_next;
            r_abort     <= w_abort_next;
            r_buf_word  <= w_buf_word_next;
            r_buf_tag   <= w_buf_tag_next;
            r_buf_valid <= w_buf_valid_next;
            s_ack_o     <= w_ack_next;
            s_dat_o     <= w_dat_next;
            m_adr_o     <= w_m_adr_next;
            m_dat_o     <= w_m_dat_next;
            m_we_o      <= w_m_we_next;
            m_sel_o     <= w_m_sel_next;
            m_stb_o     <= w_m_stb_next;
            m_cyc_o     <= w_m_cyc_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb8_xmem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb8_xmem_bridge
// Purpose  : Self-checking bench for wb8_xmem_bridge. Two instances: one with
//            the read buffer enabled, one with it disabled. A small word
//            memory model answers the downstream bus with a programmable
//            number of wait states (ack is registered, so ws=0 gives a
//            three-cycle miss as seen from the initiator).
// Revision : 1.0  initial release
// ============================================================================
module tb_wb8_xmem_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [0:23] s_adr_i;
    logic [0:7]  s_dat_i;
    logic        s_we_i;
    logic [0:0]  s_sel_i;
    logic        s_stb_i, s_cyc_i;
    logic        flush_i;

    logic [0:7]  s_dat_o;
    logic        s_ack_o;
    logic [2:23] m_adr_o;
    logic [0:31] m_dat_o;
    logic [0:31] m_dat_i = '0;
    logic        m_we_o;
    logic [0:3]  m_sel_o;
    logic        m_stb_o, m_cyc_o;
    logic        m_ack_i = 1'b0;

    logic        s_stb_nb, s_cyc_nb;
    logic [0:7]  s_dat_nb;
    logic        s_ack_nb;
    logic [2:23] m_adr_nb;
    logic [0:31] m_dat_o_nb;
    logic [0:31] m_dat_i_nb = '0;
    logic        m_we_nb;
    logic [0:3]  m_sel_nb;
    logic        m_stb_nb, m_cyc_nb;
    logic        m_ack_nb = 1'b0;

    wb8_xmem_bridge #(.READ_BUFFER(1)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .s_adr_i(s_adr_i), .s_dat_i(s_dat_i), .s_dat_o(s_dat_o),
        .s_we_i(s_we_i), .s_sel_i(s_sel_i), .s_stb_i(s_stb_i),
        .s_cyc_i(s_cyc_i), .s_ack_o(s_ack_o),
        .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i),
        .m_we_o(m_we_o), .m_sel_o(m_sel_o), .m_stb_o(m_stb_o),
        .m_cyc_o(m_cyc_o), .m_ack_i(m_ack_i), .flush_i(flush_i)
    );

    wb8_xmem_bridge #(.READ_BUFFER(0)) u_dut_nb (
        .clk(clk), .reset_n(reset_n),
        .s_adr_i(s_adr_i), .s_dat_i(s_dat_i), .s_dat_o(s_dat_nb),
        .s_we_i(s_we_i), .s_sel_i(s_sel_i), .s_stb_i(s_stb_nb),
        .s_cyc_i(s_cyc_nb), .s_ack_o(s_ack_nb),
        .m_adr_o(m_adr_nb), .m_dat_o(m_dat_o_nb), .m_dat_i(m_dat_i_nb),
        .m_we_o(m_we_nb), .m_sel_o(m_sel_nb), .m_stb_o(m_stb_nb),
        .m_cyc_o(m_cyc_nb), .m_ack_i(m_ack_nb), .flush_i(1'b0)
    );

    // ---------------- downstream memory model ----------------
    // Word index = word-address bits 9:8 (0x100 -> 1, 0x200 -> 2, 0x300 -> 3).
    logic [0:31] mem [0:3];
    logic        mem_load;
    int          ws = 0;
    int          cnt = 0;
    int          n_bus = 0;
    int          n_bus_nb = 0;

    always @(posedge clk) begin
        if (mem_load) begin
            mem[0] <= 32'h00000000;
            mem[1] <= 32'h11223344;
            mem[2] <= 32'hDEADBEEF;
            mem[3] <= 32'hCAFEF00D;
        end
        if (m_ack_i) begin
            m_ack_i <= 1'b0;
            cnt     <= 0;
        end else if (m_cyc_o && m_stb_o) begin
            if (cnt == ws) begin
                m_ack_i <= 1'b1;
                n_bus   <= n_bus + 1;
                if (m_we_o) begin
                    for (int l = 0; l < 4; l++) begin
                        if (m_sel_o[l]) mem[m_adr_o[14:15]][l*8 +: 8] <= m_dat_o[l*8 +: 8];
                    end
                end else begin
                    m_dat_i <= mem[m_adr_o[14:15]];
                end
            end else begin
                cnt <= cnt + 1;
            end
        end else begin
            cnt <= 0;
        end
        if (m_ack_nb) begin
            m_ack_nb <= 1'b0;
        end else if (m_cyc_nb && m_stb_nb) begin
            m_ack_nb   <= 1'b1;
            n_bus_nb   <= n_bus_nb + 1;
            m_dat_i_nb <= mem[m_adr_nb[14:15]];
        end
    end

    // ---------------- observation mux for the request task ----------------
    logic        tgt = 1'b0;
    logic        a_ack, a_stb, a_we;
    logic [0:7]  a_dat;
    logic [0:3]  a_sel;
    logic [0:31] a_mdat;
    assign a_ack  = tgt ? s_ack_nb   : s_ack_o;
    assign a_stb  = tgt ? m_stb_nb   : m_stb_o;
    assign a_we   = tgt ? m_we_nb    : m_we_o;
    assign a_dat  = tgt ? s_dat_nb   : s_dat_o;
    assign a_sel  = tgt ? m_sel_nb   : m_sel_o;
    assign a_mdat = tgt ? m_dat_o_nb : m_dat_o;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic do_req(input logic t, input logic [23:0] adr, input logic we,
                          input logic sel, input logic [7:0] wd, input logic flush_on_ack,
                          output logic [7:0] rd, output int lat, output logic [3:0] gsel,
                          output logic [31:0] gmd, output logic gwe);
        logic done, got;
        tgt = t; s_adr_i = adr; s_we_i = we; s_sel_i = sel; s_dat_i = wd;
        if (t) begin s_cyc_nb = 1'b1; s_stb_nb = 1'b1; end
        else   begin s_cyc_i  = 1'b1; s_stb_i  = 1'b1; end
        rd = '0; lat = 0; gsel = '0; gmd = '0; gwe = 1'b0; done = 1'b0; got = 1'b0;
        for (int i = 1; i <= 60 && !done; i++) begin
            @(negedge clk);
            flush_i = flush_on_ack && m_ack_i;
            if (a_stb && !got) begin
                got = 1'b1; gsel = a_sel; gmd = a_mdat; gwe = a_we;
            end
            if (a_ack) begin
                rd = a_dat; lat = i; done = 1'b1;
            end
        end
        s_cyc_i = 1'b0; s_stb_i = 1'b0; s_cyc_nb = 1'b0; s_stb_nb = 1'b0; flush_i = 1'b0;
        if (!done) check("ack_timeout", 64'd0, 64'd1);
    endtask

    typedef struct {
        logic        tgt;
        logic [23:0] adr;
        logic        we;
        logic        sel;
        logic [7:0]  wdat;
        logic [7:0]  exp_dat;
        int          exp_bus;
        int          exp_lat;
        logic [3:0]  exp_sel;
        logic [31:0] exp_mdat;
    } vec_t;

    vec_t vt [17];

    initial begin
        logic [7:0]  rd;
        logic [3:0]  gsel;
        logic [31:0] gmd;
        logic        gwe, acked;
        int          lat, b0, hold;

        vt[0]  = '{1'b0, 24'h000400, 1'b0, 1'b1, 8'h00, 8'h11, 1, 3, 4'b1111, 32'h0};
        vt[1]  = '{1'b0, 24'h000401, 1'b0, 1'b1, 8'h00, 8'h22, 0, 1, 4'b0000, 32'h0};
        vt[2]  = '{1'b0, 24'h000402, 1'b0, 1'b1, 8'h00, 8'h33, 0, 1, 4'b0000, 32'h0};
        vt[3]  = '{1'b0, 24'h000403, 1'b0, 1'b1, 8'h00, 8'h44, 0, 1, 4'b0000, 32'h0};
        vt[4]  = '{1'b0, 24'h000402, 1'b1, 1'b1, 8'hA5, 8'h00, 1, 3, 4'b0010, 32'hA5A5A5A5};
        vt[5]  = '{1'b0, 24'h000402, 1'b0, 1'b1, 8'h00, 8'hA5, 0, 1, 4'b0000, 32'h0};
        vt[6]  = '{1'b0, 24'h000401, 1'b1, 1'b0, 8'h77, 8'h00, 0, 1, 4'b0000, 32'h0};
        vt[7]  = '{1'b0, 24'h000401, 1'b0, 1'b1, 8'h00, 8'h22, 0, 1, 4'b0000, 32'h0};
        vt[8]  = '{1'b0, 24'h000800, 1'b0, 1'b1, 8'h00, 8'hDE, 1, 3, 4'b1111, 32'h0};
        vt[9]  = '{1'b0, 24'h000803, 1'b1, 1'b1, 8'h5A, 8'h00, 1, 3, 4'b0001, 32'h5A5A5A5A};
        vt[10] = '{1'b0, 24'h000803, 1'b0, 1'b1, 8'h00, 8'h5A, 0, 1, 4'b0000, 32'h0};
        vt[11] = '{1'b0, 24'h000800, 1'b1, 1'b1, 8'h3C, 8'h00, 1, 3, 4'b1000, 32'h3C3C3C3C};
        vt[12] = '{1'b0, 24'h000800, 1'b0, 1'b1, 8'h00, 8'h3C, 0, 1, 4'b0000, 32'h0};
        vt[13] = '{1'b1, 24'h000400, 1'b0, 1'b1, 8'h00, 8'h11, 1, 3, 4'b1111, 32'h0};
        vt[14] = '{1'b1, 24'h000401, 1'b0, 1'b1, 8'h00, 8'h22, 1, 3, 4'b1111, 32'h0};
        vt[15] = '{1'b1, 24'h000402, 1'b0, 1'b1, 8'h00, 8'hA5, 1, 3, 4'b1111, 32'h0};
        vt[16] = '{1'b1, 24'h000403, 1'b0, 1'b1, 8'h00, 8'h44, 1, 3, 4'b1111, 32'h0};

        reset_n = 1'b0; mem_load = 1'b1; flush_i = 1'b0;
        s_adr_i = '0; s_dat_i = '0; s_we_i = 1'b0; s_sel_i = 1'b0;
        s_cyc_i = 1'b0; s_stb_i = 1'b0; s_cyc_nb = 1'b0; s_stb_nb = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", {s_ack_o, m_cyc_o, m_stb_o, m_we_o, m_sel_o}, 64'd0);
        check("reset_adr_sdat", {m_adr_o, s_dat_o}, 64'd0);
        check("reset_mdat", m_dat_o, 64'd0);
        reset_n = 1'b1; mem_load = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 17; i++) begin
            b0 = vt[i].tgt ? n_bus_nb : n_bus;
            do_req(vt[i].tgt, vt[i].adr, vt[i].we, vt[i].sel, vt[i].wdat, 1'b0,
                   rd, lat, gsel, gmd, gwe);
            if (!vt[i].we) check($sformatf("v%0d_data", i), rd, vt[i].exp_dat);
            check($sformatf("v%0d_bus", i), (vt[i].tgt ? n_bus_nb : n_bus) - b0, vt[i].exp_bus);
            check($sformatf("v%0d_lat", i), lat, vt[i].exp_lat);
            if (vt[i].exp_bus > 0) begin
                check($sformatf("v%0d_sel", i), gsel, vt[i].exp_sel);
                check($sformatf("v%0d_we", i), gwe, vt[i].we);
                if (vt[i].we) check($sformatf("v%0d_mdat", i), gmd, vt[i].exp_mdat);
            end
            @(negedge clk);
        end

        // Flush between a fill and a re-read forces another downstream cycle.
        do_req(1'b0, 24'h000400, 1'b0, 1'b1, 8'h00, 1'b0, rd, lat, gsel, gmd, gwe);
        check("fl_prefill_data", rd, 8'h11);
        @(negedge clk); flush_i = 1'b1;
        @(negedge clk); flush_i = 1'b0;
        b0 = n_bus;
        do_req(1'b0, 24'h000401, 1'b0, 1'b1, 8'h00, 1'b0, rd, lat, gsel, gmd, gwe);
        check("fl_miss_data", rd, 8'h22);
        check("fl_miss_bus", n_bus - b0, 1);
        @(negedge clk);
        b0 = n_bus;
        do_req(1'b0, 24'h000402, 1'b0, 1'b1, 8'h00, 1'b0, rd, lat, gsel, gmd, gwe);
        check("fl_refill_hit_data", rd, 8'hA5);
        check("fl_refill_hit_bus", n_bus - b0, 0);
        @(negedge clk);

        // Flush on the fill edge wins: the next read of that word misses.
        do_req(1'b0, 24'h000800, 1'b0, 1'b1, 8'h00, 1'b1, rd, lat, gsel, gmd, gwe);
        check("flfill_data", rd, 8'h3C);
        @(negedge clk);
        b0 = n_bus;
        do_req(1'b0, 24'h000801, 1'b0, 1'b1, 8'h00, 1'b0, rd, lat, gsel, gmd, gwe);
        check("flfill_next_data", rd, 8'hAD);
        check("flfill_next_bus", n_bus - b0, 1);
        @(negedge clk);

        // Abort during a 5-wait-state read.
        ws = 5; b0 = n_bus; tgt = 1'b0;
        s_adr_i = 24'h000C00; s_we_i = 1'b0; s_sel_i = 1'b1; s_cyc_i = 1'b1; s_stb_i = 1'b1;
        @(negedge clk);
        s_cyc_i = 1'b0; s_stb_i = 1'b0;
        hold = 0; acked = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (s_ack_o) acked = 1'b1;
            if (!m_cyc_o) break;
            hold++;
            @(negedge clk);
        end
        repeat (3) begin
            @(negedge clk);
            if (s_ack_o) acked = 1'b1;
        end
        check("abort_cyc_hold", hold, 7);
        check("abort_no_ack", acked, 1'b0);
        check("abort_bus", n_bus - b0, 1);
        ws = 0; b0 = n_bus;
        do_req(1'b0, 24'h000C02, 1'b0, 1'b1, 8'h00, 1'b0, rd, lat, gsel, gmd, gwe);
        check("abort_hit_data", rd, 8'hF0);
        check("abort_hit_bus", n_bus - b0, 0);
        check("abort_hit_lat", lat, 1);
        @(negedge clk);

        // Reset in the middle of a downstream cycle.
        ws = 5;
        s_adr_i = 24'h000400; s_we_i = 1'b0; s_sel_i = 1'b1; s_cyc_i = 1'b1; s_stb_i = 1'b1;
        @(negedge clk);
        check("rst_mid_bus_cyc", m_cyc_o, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_ctrl", {s_ack_o, m_cyc_o, m_stb_o, m_we_o, m_sel_o}, 64'd0);
        check("rst_mid_adr_sdat", {m_adr_o, s_dat_o}, 64'd0);
        check("rst_mid_mdat", m_dat_o, 64'd0);
        s_cyc_i = 1'b0; s_stb_i = 1'b0;
        @(negedge clk); ws = 0; reset_n = 1'b1;
        @(negedge clk);
        b0 = n_bus;
        do_req(1'b0, 24'h000C01, 1'b0, 1'b1, 8'h00, 1'b0, rd, lat, gsel, gmd, gwe);
        check("rst_after_data", rd, 8'hFE);
        check("rst_after_bus", n_bus - b0, 1);
        check("rst_after_lat", lat, 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
